elevator_queue_logic: RTL and testbench



---
 rtl/elevator_pkg.sv | 24 ++
 rtl/elevator_queue_logic_shift_remove.sv | 49 ++++
 rtl/elevator_queue_logic.sv | 99 +++++++++
 tb/tb_elevator_queue_logic.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator pending-stop queue.
package elevator_pkg;

  typedef enum logic [1:0] {
    LVL_A = 2'd0,
    LVL_B = 2'd1,
    LVL_C = 2'd2,
    LVL_D = 2'd3
  } lvl_t;

  localparam int QUEUE_DEPTH = 4;
  localparam int LVL_W       = 2;
  localparam int TAIL_W      = 3;
  localparam int IDX_W       = 2;

  // Slot i sits at bits [2i+1:2i]; slot 0 is the head.
  typedef logic [QUEUE_DEPTH-1:0][LVL_W-1:0] queue_t;

  // Tail codes above the depth are treated as a full queue.
  function automatic logic [TAIL_W-1:0] eff_tail(input logic [TAIL_W-1:0] t);
    return (t > TAIL_W'(QUEUE_DEPTH)) ? TAIL_W'(QUEUE_DEPTH) : t;
  endfunction

endpackage

// File: rtl/elevator_queue_logic_shift_remove.sv
// Removes the level under the car from the valid slots, closing the gap toward the head.
module queue_shift_remove
  import elevator_pkg::*;
(
  input  logic [QUEUE_DEPTH*LVL_W-1:0] queue_i,
  input  logic [TAIL_W-1:0]            tail_i,
  input  logic [LVL_W-1:0]             lvl_i,
  output logic                         match_o,
  output logic [QUEUE_DEPTH*LVL_W-1:0] queue_o,
  output logic [TAIL_W-1:0]            tail_o
);

  queue_t                 slots;
  queue_t                 shifted;
  logic [TAIL_W-1:0]      valid_cnt;
  logic [QUEUE_DEPTH-1:0] hit;
  logic [QUEUE_DEPTH-1:0] at_or_after;

  assign slots     = queue_i;
  assign valid_cnt = eff_tail(tail_i);

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_hit
      assign hit[gi] = (TAIL_W'(gi) < valid_cnt) && (slots[gi] == lvl_i);
    end
  endgenerate

  // at_or_after[j] is set for every slot at or beyond the matched one.
  assign at_or_after[0] = hit[0];
  generate
    for (gi = 1; gi < QUEUE_DEPTH; gi++) begin : g_prefix
      assign at_or_after[gi] = at_or_after[gi-1] | hit[gi];
    end
  endgenerate

  generate
    for (gi = 0; gi < QUEUE_DEPTH - 1; gi++) begin : g_shift
      assign shifted[gi] = at_or_after[gi] ? slots[gi+1] : slots[gi];
    end
  endgenerate
  // The last slot has nothing behind it and keeps its old value.
  assign shifted[QUEUE_DEPTH-1] = slots[QUEUE_DEPTH-1];

  assign match_o = at_or_after[QUEUE_DEPTH-1];
  assign queue_o = shifted;
  assign tail_o  = match_o ? (valid_cnt - TAIL_W'(1)) : tail_i;

endmodule

// File: rtl/elevator_queue_logic.sv
// Pending-stop queue: drop the level under the car, then append an eligible new call.
// Define QUEUE_LOGIC_ASSERT_EN to compile in simulation-only consistency assertions.
module elevator_queue_logic
  import elevator_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pressed_en,
  input  logic [LVL_W-1:0]             pressed_lvl,
  input  logic [LVL_W-1:0]             pos_lvl,
  output logic [QUEUE_DEPTH*LVL_W-1:0] queue,
  output logic [TAIL_W-1:0]            tail,
  output logic                         stop_at_pos_lvl,
  output logic [QUEUE_DEPTH*LVL_W-1:0] next_queue_sub,
  output logic [TAIL_W-1:0]            next_tail_sub
);

  queue_t                 queue_q;
  queue_t                 queue_d;
  logic [TAIL_W-1:0]      tail_q;
  logic [TAIL_W-1:0]      tail_d;

  logic [QUEUE_DEPTH*LVL_W-1:0] sub_queue_flat;
  queue_t                       sub_queue;
  logic [TAIL_W-1:0]            sub_tail;
  logic [TAIL_W-1:0]            sub_eff;
  logic                         sub_match;
  logic [QUEUE_DEPTH-1:0]       dup_hit;
  logic                         add_ok;

  queue_shift_remove u_shift_remove (
    .queue_i (queue_q),
    .tail_i  (tail_q),
    .lvl_i   (pos_lvl),
    .match_o (sub_match),
    .queue_o (sub_queue_flat),
    .tail_o  (sub_tail)
  );

  assign sub_queue = sub_queue_flat;
  assign sub_eff   = eff_tail(sub_tail);

  // Duplicate check runs against the queue as it stands after the removal.
  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_dup
      assign dup_hit[gi] = (TAIL_W'(gi) < sub_eff) && (sub_queue[gi] == pressed_lvl);
    end
  endgenerate

  assign add_ok = pressed_en
               && (pressed_lvl != pos_lvl)
               && !(|dup_hit)
               && (sub_eff < TAIL_W'(QUEUE_DEPTH));

  always_comb begin
    queue_d = sub_queue;
    tail_d  = sub_tail;
    if (add_ok) begin
      queue_d[sub_eff[IDX_W-1:0]] = pressed_lvl;
      tail_d                      = sub_eff + TAIL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queue_q <= '0;
      tail_q  <= '0;
    end else begin
      queue_q <= queue_d;
      tail_q  <= tail_d;
    end
  end

  assign queue           = queue_q;
  assign tail            = tail_q;
  assign stop_at_pos_lvl = sub_match;
  assign next_queue_sub  = queue_d;
  assign next_tail_sub   = tail_d;

`ifdef QUEUE_LOGIC_ASSERT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (tail_q <= TAIL_W'(QUEUE_DEPTH));
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        for (int j = i + 1; j < QUEUE_DEPTH; j++) begin
          if (TAIL_W'(j) < tail_q) begin
            assert (queue_q[i] != queue_q[j]);
          end
        end
      end
      assert ((int'(tail_d) - int'(tail_q) <= 1) && (int'(tail_q) - int'(tail_d) <= 1));
    end
  end
`else
  // Checks compiled out; datapath is unaffected.
`endif

endmodule

// File: tb/tb_elevator_queue_logic.sv
// Self-checking bench: chained vector table, hand-built corner sequences, randomized model run.
module tb_elevator_queue_logic;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pressed_en = 1'b0;
  logic [1:0] pressed_lvl = 2'd0;
  logic [1:0] pos_lvl = 2'd0;
  logic [7:0] queue;
  logic [2:0] tail;
  logic       stop_at_pos_lvl;
  logic [7:0] next_queue_sub;
  logic [2:0] next_tail_sub;

  elevator_queue_logic dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pressed_en      (pressed_en),
    .pressed_lvl     (pressed_lvl),
    .pos_lvl         (pos_lvl),
    .queue           (queue),
    .tail            (tail),
    .stop_at_pos_lvl (stop_at_pos_lvl),
    .next_queue_sub  (next_queue_sub),
    .next_tail_sub   (next_tail_sub)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       pen;
    logic [1:0] plvl;
    logic [1:0] pos;
    logic       exp_stop;
    logic [7:0] exp_q;
    logic [2:0] exp_t;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [2:0] t;
  } sb_t;

  sb_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " queue"}, 32'(queue), 32'(e.q));
      check({tag, " tail"}, 32'(tail), 32'(e.t));
    end
  endtask

  // Drive one cycle of stimulus, check the combinational view, then the registered result.
  task automatic drive(input string tag, input logic pen, input logic [1:0] plvl,
                       input logic [1:0] pos, input logic exp_stop,
                       input logic [7:0] exp_q, input logic [2:0] exp_t);
    @(negedge clk);
    pressed_en  = pen;
    pressed_lvl = plvl;
    pos_lvl     = pos;
    #1;
    check({tag, " stop"}, 32'(stop_at_pos_lvl), 32'(exp_stop));
    check({tag, " next_queue"}, 32'(next_queue_sub), 32'(exp_q));
    check({tag, " next_tail"}, 32'(next_tail_sub), 32'(exp_t));
    sb.push_back('{q: exp_q, t: exp_t});
    @(posedge clk);
    #1;
    pop_check(tag);
    $display("%s en=%0d lvl=%0d pos=%0d -> queue=%02h tail=%0d", tag, pen, plvl, pos, queue, tail);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    pressed_en = 1'b0;
    pos_lvl    = LVL_A;
    #1;
    check("reset queue", 32'(queue), 32'h00);
    check("reset tail", 32'(tail), 32'd0);
    check("reset stop", 32'(stop_at_pos_lvl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic build_39();
    do_reset();
    drive("build B", 1'b1, LVL_B, LVL_A, 1'b0, 8'h01, 3'd1);
    drive("build C", 1'b1, LVL_C, LVL_A, 1'b0, 8'h09, 3'd2);
    drive("build D", 1'b1, LVL_D, LVL_A, 1'b0, 8'h39, 3'd3);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t       tbl[17];
    int         mq[$];
    int         nl[$];
    int         idx;
    logic       r_pen;
    logic [1:0] r_plvl;
    logic [1:0] r_pos;
    logic       exp_stop;
    logic       dup;
    logic [7:0] qv;

    // Chained sequence from reset; each row starts from the state the previous one left.
    tbl[0]  = '{1'b1, LVL_B, LVL_A, 1'b0, 8'h01, 3'd1};
    tbl[1]  = '{1'b1, LVL_C, LVL_A, 1'b0, 8'h09, 3'd2};
    tbl[2]  = '{1'b1, LVL_D, LVL_A, 1'b0, 8'h39, 3'd3};
    tbl[3]  = '{1'b0, LVL_A, LVL_C, 1'b1, 8'h0D, 3'd2};
    tbl[4]  = '{1'b0, LVL_A, LVL_C, 1'b0, 8'h0D, 3'd2};
    tbl[5]  = '{1'b1, LVL_A, LVL_D, 1'b1, 8'h01, 3'd2};
    tbl[6]  = '{1'b1, LVL_C, LVL_D, 1'b0, 8'h21, 3'd3};
    tbl[7]  = '{1'b1, LVL_D, LVL_A, 1'b1, 8'h39, 3'd3};
    tbl[8]  = '{1'b1, LVL_A, LVL_D, 1'b1, 8'h09, 3'd3};
    tbl[9]  = '{1'b1, LVL_D, LVL_B, 1'b1, 8'h32, 3'd3};
    tbl[10] = '{1'b1, LVL_B, LVL_C, 1'b1, 8'h1C, 3'd3};
    tbl[11] = '{1'b1, LVL_D, LVL_C, 1'b0, 8'h1C, 3'd3};
    tbl[12] = '{1'b0, LVL_A, LVL_D, 1'b1, 8'h04, 3'd2};
    tbl[13] = '{1'b1, LVL_B, LVL_A, 1'b1, 8'h01, 3'd1};
    tbl[14] = '{1'b0, LVL_A, LVL_B, 1'b1, 8'h00, 3'd0};
    tbl[15] = '{1'b1, LVL_A, LVL_B, 1'b0, 8'h00, 3'd1};
    tbl[16] = '{1'b1, LVL_A, LVL_C, 1'b0, 8'h00, 3'd1};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive($sformatf("vec%0d", i), tbl[i].pen, tbl[i].plvl, tbl[i].pos,
            tbl[i].exp_stop, tbl[i].exp_q, tbl[i].exp_t);
    end

    build_39();
    drive("sub_then_add", 1'b1, LVL_A, LVL_B, 1'b1, 8'h0E, 3'd3);
    build_39();
    drive("same_level_add", 1'b1, LVL_C, LVL_C, 1'b1, 8'h0D, 3'd2);
    build_39();
    drive("duplicate_add", 1'b1, LVL_C, LVL_A, 1'b0, 8'h39, 3'd3);

    // Reset in the middle of a cycle must clear state without waiting for an edge.
    build_39();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    pressed_en = 1'b0;
    #1;
    check("midreset queue", 32'(queue), 32'h00);
    check("midreset tail", 32'(tail), 32'd0);
    $display("midreset -> queue=%02h tail=%0d", queue, tail);
    @(negedge clk);
    rst_n = 1'b1;
    drive("after_release", 1'b1, LVL_B, LVL_A, 1'b0, 8'h01, 3'd1);

    // Randomized run against a list-based model; only valid slots are compared.
    do_reset();
    mq.delete();
    for (int n = 0; n < 300; n++) begin
      r_pen  = 1'($urandom_range(0, 1));
      r_plvl = 2'($urandom_range(0, 3));
      r_pos  = 2'($urandom_range(0, 3));
      @(negedge clk);
      pressed_en  = r_pen;
      pressed_lvl = r_plvl;
      pos_lvl     = r_pos;
      #1;
      idx = -1;
      foreach (mq[k]) if (mq[k] == int'(r_pos)) idx = k;
      exp_stop = (idx >= 0);
      nl = mq;
      if (idx >= 0) nl.delete(idx);
      dup = 1'b0;
      foreach (nl[k]) if (nl[k] == int'(r_plvl)) dup = 1'b1;
      if (r_pen && (r_plvl != r_pos) && !dup && (nl.size() < 4)) nl.push_back(int'(r_plvl));
      check("rand stop", 32'(stop_at_pos_lvl), 32'(exp_stop));
      check("rand next_tail", 32'(next_tail_sub), 32'(nl.size()));
      @(posedge clk);
      #1;
      check("rand tail", 32'(tail), 32'(nl.size()));
      qv = queue;
      for (int k = 0; k < nl.size(); k++) begin
        check("rand slot", 32'(qv[2*k +: 2]), 32'(nl[k]));
      end
      $display("rand%0d en=%0d lvl=%0d pos=%0d -> queue=%02h tail=%0d", n, r_pen, r_plvl, r_pos, queue, tail);
      mq = nl;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
